ps2_scan_decoder: RTL and testbench

- Receives raw PS/2 keyboard frames and turns them into the character/strobe interface consumed by the glyph mask logic.
- Interface carried: 8-bit scan code, char_check (glyph select), move_check (I/J/K/L offset step).
- Handles synchronisation of the asynchronous PS/2 lines, frame checking, break/extended prefixes and a stall watchdog.
- Sits between the board PS/2 pins and the mask producer; runs entirely in the Pixelclock domain.

---
 rtl/ps2_keys_pkg.sv | 30 +++
 rtl/ps2_frame_rx.sv | 126 ++++++++++++
 rtl/ps2_scan_decoder.sv | 92 +++++++++
 tb/tb_ps2_scan_decoder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keys_pkg.sv
// Shared PS/2 key constants and receive-frame state encoding.
// Also consumed by the glyph mask producer for its key handling.
package ps2_keys_pkg;

    localparam int unsigned CODE_W = 8;

    localparam logic [CODE_W-1:0] KEY_I     = 8'h43;
    localparam logic [CODE_W-1:0] KEY_K     = 8'h42;
    localparam logic [CODE_W-1:0] KEY_J     = 8'h3B;
    localparam logic [CODE_W-1:0] KEY_L     = 8'h4B;
    localparam logic [CODE_W-1:0] KEY_F     = 8'h2B;
    localparam logic [CODE_W-1:0] KEY_Q     = 8'h15;
    localparam logic [CODE_W-1:0] KEY_H     = 8'h33;
    localparam logic [CODE_W-1:0] KEY_X     = 8'h22;
    localparam logic [CODE_W-1:0] PS2_BREAK = 8'hF0;
    localparam logic [CODE_W-1:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // I/J/K/L step the glyph offset rather than selecting a glyph
    function automatic logic is_move_key(input logic [CODE_W-1:0] code);
        return (code == KEY_I) || (code == KEY_K) || (code == KEY_J) || (code == KEY_L);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: line synchronisers, falling-edge detect, 11-bit frame FSM,
// odd-parity/stop check and mid-frame stall watchdog.
module ps2_frame_rx
    import ps2_keys_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2500,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic              Pixelclock,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    output logic              frame_err
);

    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BIT_W = 3;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    rx_state_t         state;
    rx_state_t         state_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_cnt_next;
    logic [CODE_W-1:0] shift;
    logic [CODE_W-1:0] shift_next;
    logic              parity;
    logic              parity_next;
    logic [WD_W-1:0]   wd_cnt;
    logic [WD_W-1:0]   wd_cnt_next;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;
    assign code   = shift;

    // Synchronisers reset to the idle-high bus level so release cannot fake an edge
    always_ff @(posedge Pixelclock or negedge reset) begin
        if (!reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    always_ff @(posedge Pixelclock or negedge reset) begin
        if (!reset) begin
            state   <= RX_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            parity  <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            shift   <= shift_next;
            parity  <= parity_next;
            wd_cnt  <= wd_cnt_next;
        end
    end

    // code_valid/frame_err are asserted in the stop-edge cycle itself
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        parity_next  = parity;
        wd_cnt_next  = wd_cnt;
        code_valid   = 1'b0;
        frame_err    = 1'b0;

        if (state != RX_IDLE) begin
            wd_cnt_next = wd_cnt + WD_W'(1);
        end

        if (fall) begin
            wd_cnt_next = '0;
            case (state)
                RX_IDLE: begin
                    if (!data_s) begin
                        state_next   = RX_DATA;
                        bit_cnt_next = '0;
                    end
                end
                RX_DATA: begin
                    shift_next   = {data_s, shift[CODE_W-1:1]};
                    bit_cnt_next = bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_W'(CODE_W - 1)) begin
                        state_next = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    parity_next = data_s;
                    state_next  = RX_STOP;
                end
                RX_STOP: begin
                    if ((^{shift, parity}) && data_s) begin
                        code_valid = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                    state_next = RX_IDLE;
                end
                default: state_next = RX_IDLE;
            endcase
        end else if ((state != RX_IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1))) begin
            // Stalled mid-frame: drop the partial frame silently
            state_next   = RX_IDLE;
            shift_next   = '0;
            bit_cnt_next = '0;
            wd_cnt_next  = '0;
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 scan decoder: tracks break/extended prefixes and turns accepted make codes
// into the character plus char_check/move_check strobes for the mask producer.
module ps2_scan_decoder
    import ps2_keys_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2500,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic              Pixelclock,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic [CODE_W-1:0] character,
    output logic              char_check,
    output logic              move_check,
    output logic              frame_err
);

    logic [CODE_W-1:0] rx_code;
    logic              rx_valid;
    logic              rx_err;

    logic              brk_pending;
    logic              brk_pending_next;
    logic              ext_pending;
    logic              ext_pending_next;
    logic [CODE_W-1:0] character_next;
    logic              char_check_next;
    logic              move_check_next;
    logic              frame_err_next;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_frame_rx (
        .Pixelclock(Pixelclock),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code      (rx_code),
        .code_valid(rx_valid),
        .frame_err (rx_err)
    );

    // Prefix tracking; extended makes strobe exactly like plain ones
    always_comb begin
        brk_pending_next = brk_pending;
        ext_pending_next = ext_pending;
        character_next   = character;
        char_check_next  = 1'b0;
        move_check_next  = 1'b0;
        frame_err_next   = rx_err;

        if (rx_valid) begin
            if (rx_code == PS2_EXT) begin
                ext_pending_next = 1'b1;
            end else if (rx_code == PS2_BREAK) begin
                brk_pending_next = 1'b1;
            end else if (brk_pending) begin
                brk_pending_next = 1'b0;
                ext_pending_next = 1'b0;
            end else begin
                character_next   = rx_code;
                ext_pending_next = 1'b0;
                if (is_move_key(rx_code)) begin
                    move_check_next = 1'b1;
                end else begin
                    char_check_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Pixelclock or negedge reset) begin
        if (!reset) begin
            brk_pending <= 1'b0;
            ext_pending <= 1'b0;
            character   <= '0;
            char_check  <= 1'b0;
            move_check  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            brk_pending <= brk_pending_next;
            ext_pending <= ext_pending_next;
            character   <= character_next;
            char_check  <= char_check_next;
            move_check  <= move_check_next;
            frame_err   <= frame_err_next;
        end
    end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: bit-banged PS/2 frames against a
// keyboard-protocol reference model that tracks expected strobe counts and character.
module tb_ps2_scan_decoder;
    import ps2_keys_pkg::*;

    localparam int unsigned TIMEOUT = 2500;
    localparam int unsigned SYNC    = 2;
    localparam int          HALF    = 20;

    logic       Pixelclock = 1'b0;
    logic       reset      = 1'b0;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic [7:0] character;
    logic       char_check;
    logic       move_check;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    // observed pulse counts
    int n_char = 0;
    int n_move = 0;
    int n_err  = 0;
    int n_excl = 0;

    // reference model
    int         exp_char = 0;
    int         exp_move = 0;
    int         exp_err  = 0;
    logic [7:0] m_char   = 8'h00;
    bit         m_brk    = 1'b0;

    ps2_scan_decoder #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .Pixelclock(Pixelclock),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .character (character),
        .char_check(char_check),
        .move_check(move_check),
        .frame_err (frame_err)
    );

    always #5 Pixelclock = ~Pixelclock;

    always @(negedge Pixelclock) begin
        if (char_check === 1'b1) n_char++;
        if (move_check === 1'b1) n_move++;
        if (frame_err === 1'b1) n_err++;
        if ((char_check && move_check) || ((char_check || move_check) && frame_err)) n_excl++;
    end

    // Keyboard protocol rules: prefixes, releases and makes
    task automatic model_frame(input logic [7:0] c, input bit ok);
        if (!ok) begin
            exp_err++;
        end else if (c == 8'hE0) begin
            // extended prefix: no visible effect
        end else if (c == 8'hF0) begin
            m_brk = 1'b1;
        end else if (m_brk) begin
            m_brk = 1'b0;
        end else begin
            m_char = c;
            if (c inside {8'h43, 8'h42, 8'h3B, 8'h4B}) exp_move++;
            else exp_char++;
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge Pixelclock);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge Pixelclock);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = c;
        f[9]   = (~^c) ^ bad_par;
        f[10]  = ~bad_stop;
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge Pixelclock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) begin
            @(negedge Pixelclock);
            checks++;
            if ({character, char_check, move_check, frame_err} !== 11'd0) begin
                errors++;
                $display("FAIL reset_hold: got %h expected 000", {character, char_check, move_check, frame_err});
            end
        end
        @(posedge Pixelclock);
        #1 reset = 1'b1;
        repeat (10) @(negedge Pixelclock);
        checks++;
        if ({character, n_char, n_move, n_err} !== {8'h00, 32'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_release: char=%h c/m/e=%0d/%0d/%0d expected 00 0/0/0", character, n_char, n_move, n_err);
        end
    endtask

    task automatic test_char_make();
        send_frame(KEY_F, 1'b0, 1'b0);
        model_frame(KEY_F, 1'b1);
        checks++;
        if (n_char !== exp_char || n_move !== exp_move || n_err !== exp_err) begin
            errors++;
            $display("FAIL char_make_counts: c/m/e=%0d/%0d/%0d expected %0d/%0d/%0d", n_char, n_move, n_err, exp_char, exp_move, exp_err);
        end
        checks++;
        if (character !== 8'h2B) begin
            errors++;
            $display("FAIL char_make_value: got %h expected 2b", character);
        end
    endtask

    task automatic test_move_repeat();
        int start_move;
        start_move = n_move;
        for (int i = 0; i < 3; i++) begin
            send_frame(KEY_I, 1'b0, 1'b0);
            model_frame(KEY_I, 1'b1);
            checks++;
            if (n_char !== exp_char || n_move !== exp_move || n_err !== exp_err || character !== m_char) begin
                errors++;
                $display("FAIL move_repeat_%0d: char=%h c/m/e=%0d/%0d/%0d expected %h %0d/%0d/%0d",
                         i, character, n_char, n_move, n_err, m_char, exp_char, exp_move, exp_err);
            end
        end
        checks++;
        if (n_move - start_move !== 3) begin
            errors++;
            $display("FAIL move_repeat_total: got %0d pulses expected 3", n_move - start_move);
        end
    endtask

    task automatic test_break();
        logic [7:0] seq [4];
        seq = '{KEY_F, PS2_BREAK, KEY_F, KEY_Q};
        for (int i = 0; i < 4; i++) begin
            send_frame(seq[i], 1'b0, 1'b0);
            model_frame(seq[i], 1'b1);
            checks++;
            if (n_char !== exp_char || n_move !== exp_move || n_err !== exp_err || character !== m_char) begin
                errors++;
                $display("FAIL break_step_%0d: char=%h c/m/e=%0d/%0d/%0d expected %h %0d/%0d/%0d",
                         i, character, n_char, n_move, n_err, m_char, exp_char, exp_move, exp_err);
            end
        end
    endtask

    task automatic test_frame_errors();
        // bad parity, valid recovery, bad stop bit
        send_frame(KEY_H, 1'b1, 1'b0);
        model_frame(KEY_H, 1'b0);
        checks++;
        if (n_char !== exp_char || n_move !== exp_move || n_err !== exp_err || character !== m_char) begin
            errors++;
            $display("FAIL parity_err: char=%h c/m/e=%0d/%0d/%0d expected %h %0d/%0d/%0d",
                     character, n_char, n_move, n_err, m_char, exp_char, exp_move, exp_err);
        end
        send_frame(KEY_X, 1'b0, 1'b0);
        model_frame(KEY_X, 1'b1);
        checks++;
        if (n_char !== exp_char || n_err !== exp_err || character !== 8'h22) begin
            errors++;
            $display("FAIL parity_recover: char=%h c/e=%0d/%0d expected 22 %0d/%0d", character, n_char, n_err, exp_char, exp_err);
        end
        send_frame(KEY_J, 1'b0, 1'b1);
        model_frame(KEY_J, 1'b0);
        checks++;
        if (n_char !== exp_char || n_move !== exp_move || n_err !== exp_err || character !== m_char) begin
            errors++;
            $display("FAIL stop_err: char=%h c/m/e=%0d/%0d/%0d expected %h %0d/%0d/%0d",
                     character, n_char, n_move, n_err, m_char, exp_char, exp_move, exp_err);
        end
    endtask

    task automatic test_timeout();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
        repeat (TIMEOUT + 10) @(posedge Pixelclock);
        send_frame(KEY_L, 1'b0, 1'b0);
        model_frame(KEY_L, 1'b1);
        checks++;
        if (n_char !== exp_char || n_move !== exp_move || n_err !== exp_err || character !== 8'h4B) begin
            errors++;
            $display("FAIL timeout_recover: char=%h c/m/e=%0d/%0d/%0d expected 4b %0d/%0d/%0d",
                     character, n_char, n_move, n_err, exp_char, exp_move, exp_err);
        end
    endtask

    task automatic test_latency();
        logic [10:0] f;
        f = {1'b1, ~^KEY_H, KEY_H, 1'b0};
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge Pixelclock);
        #1 ps2_clk = 1'b0;
        repeat (SYNC) @(posedge Pixelclock);
        @(negedge Pixelclock);
        checks++;
        if (char_check !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: char_check=%b expected 0", char_check);
        end
        @(posedge Pixelclock);
        @(negedge Pixelclock);
        checks++;
        if (char_check !== 1'b1 || character !== KEY_H) begin
            errors++;
            $display("FAIL latency_hit: char_check=%b char=%h expected 1 33", char_check, character);
        end
        repeat (HALF) @(posedge Pixelclock);
        #1 ps2_clk = 1'b1;
        repeat (HALF) @(posedge Pixelclock);
        model_frame(KEY_H, 1'b1);
        checks++;
        if (n_char !== exp_char || n_move !== exp_move || n_err !== exp_err) begin
            errors++;
            $display("FAIL latency_counts: c/m/e=%0d/%0d/%0d expected %0d/%0d/%0d", n_char, n_move, n_err, exp_char, exp_move, exp_err);
        end
    endtask

    task automatic test_random();
        logic [7:0] moves [4];
        logic [7:0] c;
        bit         bad;
        int         r;
        moves = '{KEY_I, KEY_K, KEY_J, KEY_L};
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) c = PS2_BREAK;
            else if (r == 1) c = PS2_EXT;
            else if (r <= 3) c = moves[$urandom_range(0, 3)];
            else c = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 9) == 0);
            send_frame(c, bad, 1'b0);
            model_frame(c, !bad);
            checks++;
            if (n_char !== exp_char || n_move !== exp_move || n_err !== exp_err || character !== m_char) begin
                errors++;
                $display("FAIL random_%0d code=%h bad=%b: char=%h c/m/e=%0d/%0d/%0d expected %h %0d/%0d/%0d",
                         i, c, bad, character, n_char, n_move, n_err, m_char, exp_char, exp_move, exp_err);
            end
        end
    endtask

    task automatic test_reset_midframe();
        // leave a break prefix pending so reset must clear it
        send_frame(PS2_BREAK, 1'b0, 1'b0);
        model_frame(PS2_BREAK, 1'b1);
        for (int i = 0; i < 5; i++) send_bit((i == 0) ? 1'b0 : 1'b1);
        @(posedge Pixelclock);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge Pixelclock);
            checks++;
            if ({character, char_check, move_check, frame_err} !== 11'd0) begin
                errors++;
                $display("FAIL midframe_reset_hold: got %h expected 000", {character, char_check, move_check, frame_err});
            end
        end
        @(posedge Pixelclock);
        #1 reset = 1'b1;
        m_char = 8'h00;
        m_brk  = 1'b0;
        ps2_data = 1'b1;
        repeat (4 * HALF) @(negedge Pixelclock);
        checks++;
        if (n_char !== exp_char || n_move !== exp_move || n_err !== exp_err || character !== 8'h00) begin
            errors++;
            $display("FAIL midframe_reset_quiet: char=%h c/m/e=%0d/%0d/%0d expected 00 %0d/%0d/%0d",
                     character, n_char, n_move, n_err, exp_char, exp_move, exp_err);
        end
        send_frame(KEY_Q, 1'b0, 1'b0);
        model_frame(KEY_Q, 1'b1);
        checks++;
        if (n_char !== exp_char || n_move !== exp_move || n_err !== exp_err || character !== 8'h15) begin
            errors++;
            $display("FAIL midframe_reset_recover: char=%h c/m/e=%0d/%0d/%0d expected 15 %0d/%0d/%0d",
                     character, n_char, n_move, n_err, exp_char, exp_move, exp_err);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (n_excl !== 0) begin
            errors++;
            $display("FAIL strobe_exclusive: got %0d overlapping cycles expected 0", n_excl);
        end
    endtask

    initial begin
        test_reset();
        test_char_make();
        test_move_repeat();
        test_break();
        test_frame_errors();
        test_timeout();
        test_latency();
        test_random();
        test_reset_midframe();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
